vc_output_allocator: RTL and testbench

//  Packet-granular round-robin allocator for one router output port, shared by 4 input channels.

---
 rtl/router_pkg.sv | 23 ++
 rtl/vc_output_allocator_rr_pick.sv | 30 +++
 rtl/vc_output_allocator.sv | 92 +++++++++
 tb/tb_vc_output_allocator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types and constants: port count, index width, FSM and flit-type encodings.
// No logic; used by the allocators and the input channels.
// Constants only, so no latency or backpressure.
package router_pkg;

  localparam int NUM_IN    = 4;
  localparam int PORT_W    = 2;
  localparam int BUF_DEPTH = 6;

  // Output-port ownership FSM
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_t;

  // Flit type field carried in the flit header
  typedef enum logic [1:0] {
    FLIT_HEAD = 2'd0,
    FLIT_BODY = 2'd1,
    FLIT_TAIL = 2'd2
  } flit_type_t;

endpackage

// File: rtl/vc_output_allocator_rr_pick.sv
// Round-robin pick: first requester at or after ptr, as a one-hot grant plus its encoded index.
// Purely combinational, zero latency.
// No backpressure; gnt is all-zero when nothing requests.
module rr_pick
  import router_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [PORT_W-1:0] ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [PORT_W-1:0] idx
);

  logic [PORT_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest requester is the last to win
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      cand = ptr + PORT_W'(k);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/vc_output_allocator.sv
// Packet-granular round-robin owner of one output port, credit-gated toward the next hop.
// Grant one cycle after req; first pop in the grant cycle; one idle bubble after each tail.
// Stalls (holds ownership, no pop) while the owner FIFO is empty or credits are exhausted.
module vc_output_allocator #(
  parameter int NUM_IN    = router_pkg::NUM_IN,
  parameter int BUF_DEPTH = router_pkg::BUF_DEPTH,
  parameter int CW        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] flit_valid,
  input  logic [NUM_IN-1:0] flit_tail,
  input  logic              credit_ret,
  output logic [NUM_IN-1:0] gnt,
  output logic [1:0]        sel,
  output logic [NUM_IN-1:0] flit_pop,
  output logic              out_valid,
  output logic [CW-1:0]     credit_cnt,
  output logic              busy,
  output logic              err_credit
);

  import router_pkg::*;

  alloc_state_t          state, state_nxt;
  logic [PORT_W-1:0]     ptr;
  logic [NUM_IN-1:0]     pick_gnt;
  logic [PORT_W-1:0]     pick_idx;
  logic [NUM_IN-1:0]     sel_oh;
  logic                  xfer;
  logic                  release_own;
  logic                  credit_full;

  rr_pick u_rr_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign sel_oh      = NUM_IN'(1) << sel;
  assign credit_full = (credit_cnt == CW'(BUF_DEPTH));
  assign xfer        = (state == BUSY) && flit_valid[sel] && (credit_cnt != '0);
  assign release_own = xfer && flit_tail[sel];
  assign flit_pop    = xfer ? sel_oh : '0;
  assign out_valid   = |flit_pop;
  assign busy        = (state == BUSY);

  // Next-state: grab the port on any request, give it back after the tail flit crosses
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = BUSY;
      BUSY:    if (release_own) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and owner registers; the releasing owner drops to lowest priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) begin
        gnt <= pick_gnt;
        sel <= pick_idx;
      end else if (release_own) begin
        gnt <= '0;
        ptr <= sel + 2'd1;
      end
    end
  end

  // Downstream credit counter; a return with the counter already full means the peer over-returned
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= CW'(BUF_DEPTH);
      err_credit <= 1'b0;
    end else if (xfer && !credit_ret) begin
      credit_cnt <= credit_cnt - 1'b1;
    end else if (credit_ret && !xfer) begin
      if (credit_full) err_credit <= 1'b1;
      else             credit_cnt <= credit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_output_allocator.sv
// Vector-driven bench for the per-output-port round-robin credit-gated allocator.
// Checks outputs in the same cycle the inputs are applied (grant latency 1, pop combinational).
// Exercises credit exhaustion stalls, owner FIFO stalls, over-return error and mid-packet reset.
module tb_vc_output_allocator;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, flit_valid, flit_tail;
    logic       credit_ret;
    logic [3:0] gnt, flit_pop;
    logic [1:0] sel;
    logic       out_valid, busy, err_credit;
    logic [2:0] credit_cnt;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_checked = 0;
    bit run_done  = 1'b0;

    localparam int WAIT_LIMIT = 2000;

    always #5 clk = ~clk;

    vc_output_allocator #(.NUM_IN(4), .BUF_DEPTH(6), .CW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .flit_valid (flit_valid),
        .flit_tail  (flit_tail),
        .credit_ret (credit_ret),
        .gnt        (gnt),
        .sel        (sel),
        .flit_pop   (flit_pop),
        .out_valid  (out_valid),
        .credit_cnt (credit_cnt),
        .busy       (busy),
        .err_credit (err_credit)
    );

    typedef struct packed {
        logic       chk;
        logic       rst;
        logic [3:0] req;
        logic [3:0] fv;
        logic [3:0] ft;
        logic       cr;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [3:0] pop;
        logic       busy;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic c, input logic r,
                                input logic [3:0] rq, input logic [3:0] fv, input logic [3:0] ft,
                                input logic cr, input logic [3:0] g, input logic [1:0] s,
                                input logic [3:0] p, input logic b, input logic [2:0] n,
                                input logic e);
        vec_t v;
        v.chk = c;  v.rst = r;  v.req = rq; v.fv = fv; v.ft = ft; v.cr = cr;
        v.gnt = g;  v.sel = s;  v.pop = p;  v.busy = b; v.cnt = n; v.err = e;
        return v;
    endfunction

    initial begin
        int cyc;
        cyc = 0;
        while (!run_done && cyc < WAIT_LIMIT) begin
            @(posedge clk);
            cyc++;
        end
        if (!run_done) begin
            n_fail++;
            $display("FAIL timeout: vector run did not finish within %0d cycles", WAIT_LIMIT);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        vec_t v, e;
        logic [3:0] oh;
        logic [13:0] act, want;
        int n_chk_rows;

        reset = 1'b1; req = '0; flit_valid = '0; flit_tail = '0; credit_ret = 1'b0;

        @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (gnt !== 4'h0 || sel !== 2'd0 || flit_pop !== 4'h0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || credit_cnt !== 3'd6 || err_credit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: gnt=%b sel=%0d pop=%b ov=%b busy=%b cnt=%0d err=%b",
                     gnt, sel, flit_pop, out_valid, busy, credit_cnt, err_credit);
        end

        vecs.push_back(mk(0,1, 4'h0,4'h0,4'h0,0, 4'h0,0,4'h0,0,6,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,0,4'h0,0,6,0));
        vecs.push_back(mk(1,0, 4'h4,4'h4,4'h0,0, 4'h0,0,4'h0,0,6,0));
        vecs.push_back(mk(1,0, 4'h4,4'h4,4'h0,0, 4'h4,2,4'h4,1,6,0));
        vecs.push_back(mk(1,0, 4'h4,4'h4,4'h0,0, 4'h4,2,4'h4,1,5,0));
        vecs.push_back(mk(1,0, 4'h4,4'h4,4'h4,0, 4'h4,2,4'h4,1,4,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,2,4'h0,0,3,0));
        vecs.push_back(mk(1,0, 4'hF,4'h0,4'h0,0, 4'h0,2,4'h0,0,3,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h8,3,4'h0,1,3,0));
        vecs.push_back(mk(1,0, 4'h0,4'h8,4'h8,1, 4'h8,3,4'h8,1,3,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,3,4'h0,0,3,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,1, 4'h0,3,4'h0,0,3,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,1, 4'h0,3,4'h0,0,4,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,1, 4'h0,3,4'h0,0,5,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,3,4'h0,0,6,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,1, 4'h0,3,4'h0,0,6,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,3,4'h0,0,6,1));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,3,4'h0,0,6,1));
        vecs.push_back(mk(1,1, 4'h0,4'h0,4'h0,0, 4'h0,3,4'h0,0,6,1));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,0,4'h0,0,6,0));

        vecs.push_back(mk(1,0, 4'hF,4'hF,4'hF,0, 4'h0,0,4'h0,0,6,0));
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            vecs.push_back(mk(1,0, 4'hF,4'hF,4'hF,1, oh,2'(k % 4),oh,1,6,0));
            vecs.push_back(mk(1,0, (k == 4) ? 4'h0 : 4'hF,4'hF,4'hF,0, 4'h0,2'(k % 4),4'h0,0,6,0));
        end

        vecs.push_back(mk(1,0, 4'h1,4'h1,4'h0,0, 4'h0,0,4'h0,0,6,0));
        for (int j = 0; j < 6; j++)
            vecs.push_back(mk(1,0, 4'h1,4'h1,4'h0,0, 4'h1,0,4'h1,1,3'(6 - j),0));
        vecs.push_back(mk(1,0, 4'h1,4'h1,4'h0,0, 4'h1,0,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h1,4'h1,4'h0,0, 4'h1,0,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h1,4'h1,4'h0,1, 4'h1,0,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h1,4'h1,4'h0,0, 4'h1,0,4'h1,1,1,0));
        vecs.push_back(mk(1,0, 4'h1,4'h1,4'h0,0, 4'h1,0,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h1,4'h0,4'h0,1, 4'h1,0,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h1,4'h0,4'h0,1, 4'h1,0,4'h0,1,1,0));
        vecs.push_back(mk(1,0, 4'h1,4'h1,4'h1,1, 4'h1,0,4'h1,1,2,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,0,4'h0,0,2,0));

        vecs.push_back(mk(1,0, 4'h2,4'h2,4'h0,0, 4'h0,0,4'h0,0,2,0));
        vecs.push_back(mk(1,0, 4'h8,4'h2,4'h0,0, 4'h2,1,4'h2,1,2,0));
        for (int j = 0; j < 3; j++)
            vecs.push_back(mk(1,0, 4'h8,4'h0,4'h0,0, 4'h2,1,4'h0,1,1,0));
        vecs.push_back(mk(1,0, 4'h8,4'h2,4'h2,0, 4'h2,1,4'h2,1,1,0));
        vecs.push_back(mk(1,0, 4'h8,4'h0,4'h0,0, 4'h0,1,4'h0,0,0,0));
        vecs.push_back(mk(1,0, 4'h8,4'h8,4'h0,0, 4'h8,3,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h8,4'h8,4'h0,1, 4'h8,3,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h8,4'h8,4'h0,0, 4'h8,3,4'h8,1,1,0));
        vecs.push_back(mk(1,1, 4'h8,4'h8,4'h0,0, 4'h8,3,4'h0,1,0,0));
        vecs.push_back(mk(1,0, 4'h0,4'h0,4'h0,0, 4'h0,0,4'h0,0,6,0));

        n_chk_rows = 0;
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].chk) n_chk_rows++;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            reset      = v.rst;
            req        = v.req;
            flit_valid = v.fv;
            flit_tail  = v.ft;
            credit_ret = v.cr;
            if (v.chk) exp_q.push_back(v);
            @(negedge clk);
            if (v.chk) begin
                e = exp_q.pop_front();
                want = {e.gnt, e.sel, e.pop, |e.pop, e.busy, e.cnt, e.err};
                act  = {gnt, sel, flit_pop, out_valid, busy, credit_cnt, err_credit};
                n_tests++;
                n_checked++;
                if (act !== want) begin
                    n_fail++;
                    $display("FAIL row%0d: got gnt=%b sel=%0d pop=%b ov=%b busy=%b cnt=%0d err=%b, want gnt=%b sel=%0d pop=%b ov=%b busy=%b cnt=%0d err=%b",
                             i, gnt, sel, flit_pop, out_valid, busy, credit_cnt, err_credit,
                             e.gnt, e.sel, e.pop, |e.pop, e.busy, e.cnt, e.err);
                end
            end
        end

        run_done = 1'b1;

        n_tests++;
        if (n_checked != n_chk_rows) begin
            n_fail++;
            $display("FAIL coverage: %0d rows compared, %0d expected", n_checked, n_chk_rows);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
